// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues the start bit, then shifts
// a byte, odd parity and stop out on device clock falls and checks the device ACK.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [2:0] {IDLE, INHIBIT, START, SHIFT, ACK, RELEASE} state_t;

   state_t        state;
   logic [1:0]    clk_s, data_s;
   logic          clk_prev;
   logic          fall;
   logic [9:0]    frame;
   logic [3:0]    bit_cnt;
   logic [IW-1:0] inh_cnt;
   logic [TW-1:0] wdog;
   logic          wdog_hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_s    <= 2'b11;
         data_s   <= 2'b11;
         clk_prev <= 1'b1;
      end else begin
         clk_s    <= {clk_s[0], ps2_clk_in};
         data_s   <= {data_s[0], ps2_data_in};
         clk_prev <= clk_s[1];
      end
   end

   assign fall     = clk_prev & ~clk_s[1];
   assign wdog_hit = (wdog == TW'(TIMEOUT_CYCLES - 1));
   assign tx_busy  = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         frame       <= '0;
         bit_cnt     <= '0;
         inh_cnt     <= '0;
         wdog        <= '0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         tx_done     <= 1'b0;
         tx_error    <= 1'b0;
      end else begin
         tx_done  <= 1'b0;
         tx_error <= 1'b0;
         // watchdog runs from START entry onward and saturates at its limit
         if (state != IDLE && state != INHIBIT && !wdog_hit)
            wdog <= wdog + 1'b1;
         case (state)
            IDLE: begin
               if (tx_start) begin
                  frame       <= {1'b1, ~^tx_data, tx_data};
                  bit_cnt     <= '0;
                  inh_cnt     <= '0;
                  ps2_clk_oe  <= 1'b1;
                  ps2_data_oe <= 1'b0;
                  state       <= INHIBIT;
               end
            end
            INHIBIT: begin
               if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b1;
                  wdog        <= '0;
                  state       <= START;
               end else begin
                  inh_cnt <= inh_cnt + 1'b1;
               end
            end
            default: begin
               if (wdog_hit) begin
                  tx_error    <= 1'b1;
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  state       <= IDLE;
               end else begin
                  case (state)
                     START: if (fall) begin
                        ps2_data_oe <= ~frame[0];
                        bit_cnt     <= 4'd1;
                        state       <= SHIFT;
                     end
                     SHIFT: if (fall) begin
                        // a 0 bit is driven by pulling the line, a 1 bit by releasing it
                        ps2_data_oe <= ~frame[bit_cnt];
                        if (bit_cnt >= 4'd9) state <= ACK;
                        else                 bit_cnt <= bit_cnt + 4'd1;
                     end
                     ACK: if (fall) begin
                        if (!data_s[1]) begin
                           state <= RELEASE;
                        end else begin
                           tx_error <= 1'b1;
                           state    <= IDLE;
                        end
                     end
                     RELEASE: if (clk_s[1] && data_s[1]) begin
                        tx_done <= 1'b1;
                        state   <= IDLE;
                     end
                     default: state <= IDLE;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple open-drain PS/2 device model.
module tb_ps2_host_tx;
   localparam int INH  = 5000;
   localparam int TMO  = 12000;
   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_start = 1'b0;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       ps2_clk_in, ps2_data_in;
   logic       ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   bit both_seen = 1'b0;

   assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
   assign ps2_data_in = dev_data & ~ps2_data_oe;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
      .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
      .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_done) done_cnt++;
      if (tx_error) err_cnt++;
      if (tx_done && tx_error) both_seen = 1'b1;
   end

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      tx_data  = b;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
   endtask

   task automatic wait_start(input string name);
      int n = 0;
      while (!(ps2_data_oe && !ps2_clk_oe) && n < INH + 100) begin
         @(negedge clk);
         n++;
      end
      if (!(ps2_data_oe && !ps2_clk_oe)) begin
         checks++; errors++;
         $display("FAIL %s start bit: not seen within %0d cycles", name, INH + 100);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (tx_busy && n < 300) begin
         @(negedge clk);
         n++;
      end
   endtask

   // device generates nedges clock pulses; obs[0] is the start bit, obs[k] the bit after fall k
   task automatic dev_clock(input int nedges, input bit ack, output logic [10:0] obs);
      obs    = '0;
      obs[0] = ~ps2_data_oe;
      for (int i = 0; i < nedges; i++) begin
         if (i == 10 && ack) dev_data = 1'b0;
         repeat (HALF) @(negedge clk);
         dev_clk = 1'b0;
         repeat (HALF / 2) @(negedge clk);
         if (i < 10) obs[i+1] = ~ps2_data_oe;
         repeat (HALF / 2) @(negedge clk);
         dev_clk = 1'b1;
      end
      if (ack) begin
         repeat (5) @(negedge clk);
         dev_data = 1'b1;
      end
   endtask

   task automatic check_frame(input string name, input logic [7:0] b, input logic [10:0] obs);
      logic [10:0] exp;
      exp = {1'b1, ~^b, b, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s frame: got %b, expected %b", name, obs, exp);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks += 4;
      if (ps2_clk_oe !== 1'b0)  begin errors++; $display("FAIL reset clk_oe: got %b, expected 0", ps2_clk_oe); end
      if (ps2_data_oe !== 1'b0) begin errors++; $display("FAIL reset data_oe: got %b, expected 0", ps2_data_oe); end
      if (tx_busy !== 1'b0)     begin errors++; $display("FAIL reset busy: got %b, expected 0", tx_busy); end
      if ((tx_done | tx_error) !== 1'b0) begin errors++; $display("FAIL reset pulses: got %b%b, expected 00", tx_done, tx_error); end
      reset = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_send_ed();
      logic [10:0] obs;
      int d0 = done_cnt, e0 = err_cnt;
      send(8'hED);
      wait_start("ed");
      dev_clock(11, 1'b1, obs);
      wait_idle();
      repeat (5) @(negedge clk);
      check_frame("ed", 8'hED, obs);
      checks += 3;
      if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ed done pulses: got %0d, expected 1", done_cnt - d0); end
      if (err_cnt - e0 !== 0)  begin errors++; $display("FAIL ed error pulses: got %0d, expected 0", err_cnt - e0); end
      if (tx_busy !== 1'b0)    begin errors++; $display("FAIL ed busy after done: got %b, expected 0", tx_busy); end
   endtask

   task automatic test_parity_inhibit();
      logic [10:0] obs;
      int d0 = done_cnt, cnt, n;
      send(8'h01);
      cnt = ps2_clk_oe ? 1 : 0;
      n = 0;
      while (!ps2_data_oe && n < INH + 100) begin
         @(negedge clk);
         n++;
         if (ps2_clk_oe) cnt++;
      end
      checks++;
      if (cnt !== INH) begin errors++; $display("FAIL inhibit length: got %0d cycles, expected %0d", cnt, INH); end
      dev_clock(11, 1'b1, obs);
      wait_idle();
      repeat (5) @(negedge clk);
      checks += 2;
      if (obs[9] !== 1'b0) begin errors++; $display("FAIL 01 parity: got %b, expected 0", obs[9]); end
      if (done_cnt - d0 !== 1) begin errors++; $display("FAIL 01 done pulses: got %0d, expected 1", done_cnt - d0); end
      check_frame("01", 8'h01, obs);
   endtask

   task automatic test_nack();
      logic [10:0] obs;
      int d0 = done_cnt, e0 = err_cnt;
      send(8'h5A);
      wait_start("nack");
      dev_clock(11, 1'b0, obs);
      repeat (10) @(negedge clk);
      checks += 5;
      if (err_cnt - e0 !== 1)   begin errors++; $display("FAIL nack error pulses: got %0d, expected 1", err_cnt - e0); end
      if (done_cnt - d0 !== 0)  begin errors++; $display("FAIL nack done pulses: got %0d, expected 0", done_cnt - d0); end
      if (ps2_clk_oe !== 1'b0)  begin errors++; $display("FAIL nack clk_oe: got %b, expected 0", ps2_clk_oe); end
      if (ps2_data_oe !== 1'b0) begin errors++; $display("FAIL nack data_oe: got %b, expected 0", ps2_data_oe); end
      if (tx_busy !== 1'b0)     begin errors++; $display("FAIL nack busy: got %b, expected 0", tx_busy); end
   endtask

   task automatic test_timeout();
      int cnt = 0;
      send(8'h12);
      wait_start("timeout");
      while (!tx_error && cnt < 2 * TMO) begin
         @(negedge clk);
         cnt++;
      end
      checks += 3;
      if (cnt !== TMO) begin errors++; $display("FAIL timeout latency: got %0d cycles, expected %0d", cnt, TMO); end
      if ((ps2_clk_oe | ps2_data_oe) !== 1'b0) begin errors++; $display("FAIL timeout lines: got oe %b%b, expected 00", ps2_clk_oe, ps2_data_oe); end
      @(negedge clk);
      if (tx_busy !== 1'b0) begin errors++; $display("FAIL timeout busy: got %b, expected 0", tx_busy); end
   endtask

   task automatic test_ignore_busy();
      logic [10:0] obs;
      int d0 = done_cnt;
      bit restarted = 1'b0;
      send(8'hF4);
      wait_start("ignore");
      fork
         dev_clock(11, 1'b1, obs);
         begin
            repeat (150) @(negedge clk);
            tx_data  = 8'hAA;
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
         end
      join
      wait_idle();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ps2_clk_oe || tx_busy) restarted = 1'b1;
      end
      check_frame("ignore", 8'hF4, obs);
      checks += 2;
      if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ignore done pulses: got %0d, expected 1", done_cnt - d0); end
      if (restarted !== 1'b0)  begin errors++; $display("FAIL ignore second start: got restart %b, expected 0", restarted); end
   endtask

   task automatic test_reset_mid();
      logic [10:0] obs;
      int d0 = done_cnt, e0 = err_cnt;
      send(8'h33);
      wait_start("rstmid");
      dev_clock(4, 1'b0, obs);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks += 4;
      if (ps2_clk_oe !== 1'b0)  begin errors++; $display("FAIL rstmid clk_oe: got %b, expected 0", ps2_clk_oe); end
      if (ps2_data_oe !== 1'b0) begin errors++; $display("FAIL rstmid data_oe: got %b, expected 0", ps2_data_oe); end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      if (done_cnt - d0 !== 0) begin errors++; $display("FAIL rstmid done pulses: got %0d, expected 0", done_cnt - d0); end
      if (err_cnt - e0 !== 0)  begin errors++; $display("FAIL rstmid error pulses: got %0d, expected 0", err_cnt - e0); end
      d0 = done_cnt;
      send(8'hFF);
      wait_start("ff");
      dev_clock(11, 1'b1, obs);
      wait_idle();
      repeat (5) @(negedge clk);
      check_frame("ff", 8'hFF, obs);
      checks += 2;
      if (obs[9] !== 1'b1)     begin errors++; $display("FAIL ff parity: got %b, expected 1", obs[9]); end
      if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ff done pulses: got %0d, expected 1", done_cnt - d0); end
   endtask

   initial begin
      test_reset();
      test_send_ed();
      test_parity_inhibit();
      test_nack();
      test_timeout();
      test_ignore_busy();
      test_reset_mid();
      checks++;
      if (both_seen !== 1'b0) begin errors++; $display("FAIL done_error_overlap: got %b, expected 0", both_seen); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
